// File: rtl/coproc_arbiter.sv
// Two-requester round-robin front end for the matrix coprocessor: latches one request,
// drives the core, and returns the captured result with a one-cycle done pulse.
module coproc_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_coprocessor,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [4:0]   instr0,
    input  logic [4:0]   instr1,
    input  logic [199:0] mat_a0,
    input  logic [199:0] mat_b0,
    input  logic [199:0] mat_a1,
    input  logic [199:0] mat_b1,
    output logic         core_start,
    output logic [4:0]   core_instruction,
    output logic [199:0] core_matrix1,
    output logic [199:0] core_matrix2,
    input  logic [199:0] core_result,
    input  logic         core_ready,
    input  logic         core_overflow,
    output logic         done0,
    output logic         done1,
    output logic [199:0] result,
    output logic         ovf_out,
    output logic         timeout_err,
    output logic         illegal_op,
    output logic         grant_id,
    output logic         busy
);

    localparam int               CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       OP_ILLEGAL = 3'b111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        RESPOND = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic [CNT_W-1:0] wait_cnt;

    logic             any_req;
    logic             win_id;
    logic             win_illegal;
    logic             owner_req;
    logic             timed_out;
    logic [4:0]       win_instr;
    logic [199:0]     win_a;
    logic [199:0]     win_b;

    // A lone request wins outright; on a tie the requester not served last time wins.
    function automatic logic arbitrate(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

    always_comb begin
        any_req     = req0 | req1;
        win_id      = arbitrate(req0, req1, last_grant);
        win_instr   = win_id ? instr1 : instr0;
        win_a       = win_id ? mat_a1 : mat_a0;
        win_b       = win_id ? mat_b1 : mat_b0;
        win_illegal = (win_instr[4:2] == OP_ILLEGAL);
        owner_req   = grant_id ? req1 : req0;
        timed_out   = (wait_cnt == CNT_LAST);
    end

    always_ff @(posedge clk_coprocessor or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = win_illegal ? RESPOND : ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (core_ready || timed_out) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: state_next = RELEASE;
            RELEASE: begin
                if (!owner_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        core_start = (state == ISSUE);
        done0      = (state == RESPOND) && !grant_id;
        done1      = (state == RESPOND) && grant_id;
        busy       = (state != IDLE);
    end

    // Operation registers; a core_ready arriving while still in ISSUE is stale and ignored.
    always_ff @(posedge clk_coprocessor or posedge rst) begin
        if (rst) begin
            last_grant       <= 1'b1;
            grant_id         <= 1'b0;
            wait_cnt         <= '0;
            core_instruction <= '0;
            core_matrix1     <= '0;
            core_matrix2     <= '0;
            result           <= '0;
            ovf_out          <= 1'b0;
            timeout_err      <= 1'b0;
            illegal_op       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id         <= win_id;
                        core_instruction <= win_instr;
                        core_matrix1     <= win_a;
                        core_matrix2     <= win_b;
                        illegal_op       <= win_illegal;
                        timeout_err      <= 1'b0;
                        if (win_illegal) begin
                            result  <= '0;
                            ovf_out <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (core_ready) begin
                        result      <= core_result;
                        ovf_out     <= core_overflow;
                        timeout_err <= 1'b0;
                    end else if (timed_out) begin
                        result      <= '0;
                        ovf_out     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    last_grant <= grant_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coproc_arbiter.sv
// Randomized bench for coproc_arbiter: a transaction-level model predicts winner, latency
// and captured outputs of each operation while the bench plays the role of the matrix core.
module tb_coproc_arbiter;

    localparam int T = 64;

    logic         clk_coprocessor = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [4:0]   instr0, instr1;
    logic [199:0] mat_a0, mat_b0, mat_a1, mat_b1;
    logic         core_start;
    logic [4:0]   core_instruction;
    logic [199:0] core_matrix1, core_matrix2;
    logic [199:0] core_result;
    logic         core_ready, core_overflow;
    logic         done0, done1;
    logic [199:0] result;
    logic         ovf_out, timeout_err, illegal_op, grant_id, busy;

    int   checks = 0;
    int   errors = 0;
    logic model_last = 1'b1;

    coproc_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk_coprocessor (clk_coprocessor),
        .rst             (rst),
        .req0            (req0),
        .req1            (req1),
        .instr0          (instr0),
        .instr1          (instr1),
        .mat_a0          (mat_a0),
        .mat_b0          (mat_b0),
        .mat_a1          (mat_a1),
        .mat_b1          (mat_b1),
        .core_start      (core_start),
        .core_instruction(core_instruction),
        .core_matrix1    (core_matrix1),
        .core_matrix2    (core_matrix2),
        .core_result     (core_result),
        .core_ready      (core_ready),
        .core_overflow   (core_overflow),
        .done0           (done0),
        .done1           (done1),
        .result          (result),
        .ovf_out         (ovf_out),
        .timeout_err     (timeout_err),
        .illegal_op      (illegal_op),
        .grant_id        (grant_id),
        .busy            (busy)
    );

    always #5 clk_coprocessor = ~clk_coprocessor;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] rand200();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[199:0];
    endfunction

    function automatic logic [4:0] rand_legal();
        return {3'($urandom_range(0, 6)), 2'($urandom_range(0, 3))};
    endfunction

    task automatic tick();
        @(posedge clk_coprocessor);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [4:0] ins);
        if (idx == 0) begin
            req0 = 1'b1; instr0 = ins; mat_a0 = rand200(); mat_b0 = rand200();
        end else begin
            req1 = 1'b1; instr1 = ins; mat_a1 = rand200(); mat_b1 = rand200();
        end
    endtask

    task automatic drop_req(input logic id);
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
    endtask

    // delay: WAIT cycle (1..T) in which core_ready is pulsed, 0 = never.
    task automatic run_op(input int delay, input bit stale, input bit drop_early,
                          input int hold, output logic got_id);
        logic         exp_id, exp_ovf, exp_ill, exp_to, ready_ovf;
        logic [4:0]   exp_instr;
        logic [199:0] exp_a, exp_b, exp_res, ready_val;
        int           exp_k, starts, dones, done_k;

        check_val("idle_before_op", 200'(busy), '0);
        exp_id    = (req0 && req1) ? ~model_last : req1;
        exp_instr = exp_id ? instr1 : instr0;
        exp_a     = exp_id ? mat_a1 : mat_a0;
        exp_b     = exp_id ? mat_b1 : mat_b0;
        exp_ill   = (exp_instr[4:2] == 3'b111);
        ready_val = rand200();
        ready_ovf = 1'($urandom_range(0, 1));
        if (exp_ill) begin
            exp_k = 1; exp_res = '0; exp_ovf = 1'b0; exp_to = 1'b0;
        end else if (delay >= 1 && delay <= T) begin
            exp_k = delay + 2; exp_res = ready_val; exp_ovf = ready_ovf; exp_to = 1'b0;
        end else begin
            exp_k = T + 2; exp_res = '0; exp_ovf = 1'b0; exp_to = 1'b1;
        end
        starts = 0; dones = 0; done_k = 0; got_id = 1'b0;

        for (int k = 1; k <= T + 8 && dones == 0; k++) begin
            tick();
            core_ready = 1'b0; core_overflow = 1'b0; core_result = rand200();
            if (core_start) begin
                starts++;
                check_val("issue_instr", 200'(core_instruction), 200'(exp_instr));
                check_val("issue_mat1", core_matrix1, exp_a);
                check_val("issue_mat2", core_matrix2, exp_b);
                if (stale) begin
                    core_ready = 1'b1; core_overflow = ~ready_ovf;
                end
            end
            if (!exp_ill && delay >= 1 && k == delay + 1) begin
                core_ready = 1'b1; core_result = ready_val; core_overflow = ready_ovf;
            end
            if (drop_early && k == 2) drop_req(exp_id);
            if (done0 || done1) begin
                dones++; done_k = k; got_id = grant_id;
                check_val("done0_line", 200'(done0), 200'(!exp_id));
                check_val("done1_line", 200'(done1), 200'(exp_id));
                check_val("grant_id", 200'(grant_id), 200'(exp_id));
                check_val("result", result, exp_res);
                check_val("ovf_out", 200'(ovf_out), 200'(exp_ovf));
                check_val("timeout_err", 200'(timeout_err), 200'(exp_to));
                check_val("illegal_op", 200'(illegal_op), 200'(exp_ill));
                check_val("held_instr", 200'(core_instruction), 200'(exp_instr));
            end
        end
        core_ready = 1'b0;
        check_val("done_count", 200'(dones), 200'(1));
        check_val("start_count", 200'(starts), exp_ill ? 200'(0) : 200'(1));
        check_val("done_latency", 200'(done_k), 200'(exp_k));
        model_last = exp_id;

        tick();
        check_val("done_one_cycle", 200'(done0 | done1), '0);
        check_val("release_busy", 200'(busy), 200'(1));
        for (int h = 0; h < hold; h++) begin
            tick();
            check_val("release_hold", 200'({busy, done0 | done1}), 200'(2'b10));
        end
        drop_req(exp_id);
        tick();
        check_val("back_idle", 200'(busy), '0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"},
                  200'({busy, core_start, done0, done1, ovf_out, timeout_err, illegal_op, grant_id}), '0);
        check_val({tag, "_instr"}, 200'(core_instruction), '0);
        check_val({tag, "_mat1"}, core_matrix1, '0);
        check_val({tag, "_mat2"}, core_matrix2, '0);
        check_val({tag, "_result"}, result, '0);
    endtask

    initial begin
        logic g;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; instr0 = '0; instr1 = '0;
        mat_a0 = '0; mat_b0 = '0; mat_a1 = '0; mat_b1 = '0;
        core_result = '0; core_ready = 1'b0; core_overflow = 1'b0;
        repeat (2) @(posedge clk_coprocessor);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Round-robin from reset: 0, then 1, then 0 again on a fresh tie.
        set_req(0, rand_legal()); set_req(1, rand_legal());
        run_op(2, 1'b0, 1'b0, 1, g); check_val("rr_first", 200'(g), '0);
        run_op(4, 1'b0, 1'b0, 0, g); check_val("rr_second", 200'(g), 200'(1));
        set_req(0, rand_legal()); set_req(1, rand_legal());
        run_op(1, 1'b0, 1'b0, 2, g); check_val("rr_third", 200'(g), '0);
        run_op(3, 1'b0, 1'b0, 0, g); check_val("rr_fourth", 200'(g), 200'(1));

        set_req(0, 5'b00001);
        run_op(3, 1'b0, 1'b0, 1, g); check_val("basic_grant", 200'(g), '0);
        set_req(0, rand_legal());
        run_op(0, 1'b0, 1'b0, 0, g);
        set_req(1, 5'b11100);
        run_op(0, 1'b0, 1'b0, 0, g); check_val("illegal_grant", 200'(g), 200'(1));
        set_req(0, rand_legal());
        run_op(2, 1'b1, 1'b0, 0, g);
        set_req(1, rand_legal());
        run_op(T, 1'b0, 1'b0, 0, g);
        set_req(0, rand_legal());
        run_op(5, 1'b0, 1'b1, 0, g);

        // Asynchronous reset in the middle of WAIT.
        set_req(0, rand_legal());
        tick();
        check_val("pre_rst_start", 200'(core_start), 200'(1));
        tick();
        tick();
        #1 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        req0 = 1'b0;
        #1 rst = 1'b0;
        model_last = 1'b1;
        tick();
        check_val("post_rst_idle", 200'(busy), '0);
        set_req(1, rand_legal());
        run_op(4, 1'b0, 1'b0, 0, g); check_val("post_rst_grant", 200'(g), 200'(1));

        for (int i = 0; i < 40; i++) begin
            int dly, hd;
            bit st, de;
            if (!req0 && $urandom_range(0, 9) < 6) set_req(0, 5'($urandom()));
            if (!req1 && $urandom_range(0, 9) < 6) set_req(1, 5'($urandom()));
            if (!req0 && !req1) set_req(int'($urandom_range(0, 1)), 5'($urandom()));
            dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
            if ($urandom_range(0, 15) == 0) dly = T;
            st = ($urandom_range(0, 3) == 0);
            de = ($urandom_range(0, 4) == 0);
            hd = de ? 0 : int'($urandom_range(0, 3));
            run_op(dly, st, de, hd, g);
        end

        req0 = 1'b0; req1 = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
